// File: rtl/ps2_pkg.sv
// Purpose: shared PS/2 constants, transmit FSM encoding and parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  // Frame layout: 8 data bits, then parity, stop, and the device ACK on edge 11.
  localparam int DATA_BITS   = 8;
  localparam int PARITY_EDGE = DATA_BITS + 1;
  localparam int ACK_EDGE    = 11;

  // Default timing at a 25 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES = 2500;    // 100 us
  localparam int DEF_TIMEOUT_CYCLES = 375000;  // 15 ms

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  // PS/2 uses odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Purpose: 2-flop synchronizer for one raw PS/2 line plus falling-edge detect.
// Latency: level valid 2 clk after the pin; fall pulses 1 clk wide, 2 clk after the pin drops.
// Backpressure: none; free-running sampler.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic lvl,
  output logic fall
);

  logic meta;
  logic cur;
  logic prev;

  // Resync chain; flops reset high to match an idle (released) bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= raw;
      cur  <= meta;
      prev <= cur;
    end
  end

  assign lvl  = cur;
  assign fall = prev & ~cur;

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose: host-to-device PS/2 command transmitter (inhibit, request-to-send, 8N-odd frame, ACK check).
// Latency: INHIBIT_CYCLES + 11 device clocks + line idle; drive changes 1 clk after a detected fall.
// Backpressure: tx_start is ignored while tx_busy is high; no queueing.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low
);

  localparam int IN_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IN_W-1:0] IN_START = IN_W'(INHIBIT_CYCLES - 2);
  localparam logic [IN_W-1:0] IN_LAST  = IN_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]      PAR_E    = 4'(PARITY_EDGE);
  localparam logic [3:0]      ACK_E    = 4'(ACK_EDGE);

  logic c_lvl, c_fall, d_lvl, d_fall_unused;

  ps2_line_sync u_sync_c (.clk(clk), .reset(reset), .raw(ps2c_in), .lvl(c_lvl), .fall(c_fall));
  ps2_line_sync u_sync_d (.clk(clk), .reset(reset), .raw(ps2d_in), .lvl(d_lvl), .fall(d_fall_unused));

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic                 par_q, par_n;
  logic                 ack_q, ack_n;
  logic [IN_W-1:0]      inh_cnt, inh_n;
  logic [3:0]           edge_cnt, edge_n;
  logic [TO_W-1:0]      to_cnt, to_n;
  logic                 cd_q, cd_n, dd_q, dd_n;
  logic                 done_n, err_n;
  logic                 in_frame;

  assign in_frame = (state != IDLE) && (state != INHIBIT);

  // State, shift register, counters and registered line drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      ack_q    <= 1'b0;
      inh_cnt  <= '0;
      edge_cnt <= '0;
      to_cnt   <= '0;
      cd_q     <= 1'b0;
      dd_q     <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_n;
      data_q   <= data_n;
      par_q    <= par_n;
      ack_q    <= ack_n;
      inh_cnt  <= inh_n;
      edge_cnt <= edge_n;
      to_cnt   <= to_n;
      cd_q     <= cd_n;
      dd_q     <= dd_n;
      tx_done  <= done_n;
      tx_error <= err_n;
    end
  end

  // Next-state, next-drive and pulse generation.
  always_comb begin
    state_n = state;
    data_n  = data_q;
    par_n   = par_q;
    ack_n   = ack_q;
    inh_n   = inh_cnt;
    edge_n  = edge_cnt;
    to_n    = to_cnt;
    cd_n    = cd_q;
    dd_n    = dd_q;
    done_n  = 1'b0;
    err_n   = 1'b0;

    if (in_frame && to_cnt == TO_LAST) begin
      // Device went silent too long: let go of both lines and report.
      state_n = IDLE;
      cd_n    = 1'b0;
      dd_n    = 1'b0;
      to_n    = '0;
      err_n   = 1'b1;
    end else begin
      // The watchdog restarts on every device clock, bounding the longest silence.
      if (in_frame) begin
        if (to_cnt != TO_MAX) to_n = to_cnt + 1'b1;
        if (c_fall) begin
          to_n = '0;
          if (edge_cnt != 4'hF) edge_n = edge_cnt + 4'd1;
        end
      end

      case (state)
        IDLE: begin
          cd_n = 1'b0;
          dd_n = 1'b0;
          if (tx_start) begin
            data_n  = tx_data;
            par_n   = odd_parity(tx_data);
            inh_n   = '0;
            edge_n  = '0;
            cd_n    = 1'b1;
            state_n = INHIBIT;
          end
        end
        INHIBIT: begin
          inh_n = inh_cnt + 1'b1;
          if (inh_cnt == IN_START) dd_n = 1'b1;  // start bit in the final inhibit cycle
          if (inh_cnt == IN_LAST) begin
            cd_n    = 1'b0;
            dd_n    = 1'b1;
            to_n    = '0;
            state_n = REQ;
          end
        end
        REQ: begin
          if (c_fall) begin
            dd_n    = ~data_q[0];
            data_n  = data_q >> 1;
            state_n = DATA;
          end
        end
        DATA: begin
          if (c_fall) begin
            if (edge_cnt + 4'd1 == PAR_E) begin
              dd_n    = ~par_q;
              state_n = PARITY;
            end else begin
              dd_n   = ~data_q[0];
              data_n = data_q >> 1;
            end
          end
        end
        PARITY: begin
          if (c_fall) begin
            dd_n    = 1'b0;  // stop bit: release the line
            state_n = STOP;
          end
        end
        STOP: begin
          if (c_fall && (edge_cnt + 4'd1 == ACK_E)) begin
            ack_n   = d_lvl;
            state_n = ACK;
          end
        end
        ACK: begin
          if (ack_q) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (c_lvl && d_lvl) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign tx_busy        = (state != IDLE);
  assign ps2c_drive_low = cd_q;
  assign ps2d_drive_low = dd_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Purpose: self-checking bench for ps2_host_tx with a PS/2 device model and bit scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_host_tx;

  localparam int INH  = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2c_drive_low, ps2d_drive_low;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       ps2c_in, ps2d_in;

  // Open-drain wired-AND of host and device.
  assign ps2c_in = ~(ps2c_drive_low | dev_c_low);
  assign ps2d_in = ~(ps2d_drive_low | dev_d_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_drive_low(ps2c_drive_low), .ps2d_drive_low(ps2d_drive_low)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Line/pulse monitor sampled on the falling clock edge.
  int cyc = 0;
  int n_done = 0, n_err = 0, n_both = 0;
  int rel_cyc = 0, err_cyc = 0;
  int inh_run = 0, inh_len = 0, inh_dd = 0, inh_dd_acc = 0, hi_changes = 0;
  logic prev_dd = 1'b0, prev_c = 1'b1, prev_cd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_error) begin n_err++; err_cyc = cyc; end
    if (tx_done && tx_error) n_both++;
    if (prev_cd && !ps2c_drive_low) rel_cyc = cyc;
    if (ps2c_drive_low) begin
      inh_run++;
      if (ps2d_drive_low) inh_dd_acc++;
    end else if (inh_run > 0) begin
      inh_len = inh_run; inh_dd = inh_dd_acc; inh_run = 0; inh_dd_acc = 0;
    end
    if (tx_busy && prev_c && ps2c_in && (ps2d_drive_low != prev_dd)) hi_changes++;
    prev_dd = ps2d_drive_low; prev_c = ps2c_in; prev_cd = ps2c_drive_low;
  end

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    tx_data = d; tx_start = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(~^d);
    exp_q.push_back(1'b1);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks 11 edges, samples on rising clock.
  task automatic device(input bit ack, input int stop_after);
    int t;
    logic e_bit;
    t = 0;
    while (!(ps2c_drive_low == 1'b0 && ps2d_drive_low == 1'b1) && t < 2000) begin
      @(negedge clk); t++;
    end
    chk("req_seen", (t < 2000), 1);
    if (t >= 2000) return;
    repeat (HALF) @(negedge clk);
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (e == stop_after) begin
        dev_c_low = 1'b0; dev_d_low = 1'b0;
        return;
      end
      dev_c_low = 1'b0;
      if (e <= 10) begin
        e_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        chk($sformatf("bit_e%0d", e), ps2d_in, e_bit);
      end
      repeat (HALF) @(negedge clk);
    end
    dev_d_low = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (tx_busy && t < 600) begin @(negedge clk); t++; end
    chk("busy_drops", tx_busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, e0;
    repeat (3) @(negedge clk);
    chk("rst_busy", tx_busy, 0);
    chk("rst_cdrv", ps2c_drive_low, 0);
    chk("rst_ddrv", ps2d_drive_low, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED with ACK
    d0 = n_done; e0 = n_err;
    start_frame(8'hED); device(1, 0); wait_idle();
    chk("ed_inhibit_len", inh_len, INH);
    chk("ed_start_in_last", inh_dd, 1);
    chk("ed_done", n_done - d0, 1);
    chk("ed_err", n_err - e0, 0);
    chk("ed_sb_empty", exp_q.size(), 0);

    // 0xF4: parity bit 0
    d0 = n_done; e0 = n_err;
    start_frame(8'hF4); device(1, 0); wait_idle();
    chk("f4_done", n_done - d0, 1);
    chk("f4_err", n_err - e0, 0);

    // Device leaves data high on the ACK edge
    d0 = n_done; e0 = n_err;
    start_frame(8'h5A); device(0, 0); wait_idle();
    chk("nak_err", n_err - e0, 1);
    chk("nak_done", n_done - d0, 0);
    chk("nak_cdrv", ps2c_drive_low, 0);
    chk("nak_ddrv", ps2d_drive_low, 0);

    // Device never clocks
    d0 = n_done; e0 = n_err;
    start_frame(8'h3C); wait_idle();
    exp_q.delete();
    chk("to_err", n_err - e0, 1);
    chk("to_done", n_done - d0, 0);
    chk("to_latency", err_cyc - rel_cyc, TO);
    chk("to_cdrv", ps2c_drive_low, 0);
    chk("to_ddrv", ps2d_drive_low, 0);

    // Reset mid-frame after edge 4
    d0 = n_done; e0 = n_err;
    start_frame(8'hED); device(1, 4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_cdrv", ps2c_drive_low, 0);
    chk("mid_rst_ddrv", ps2d_drive_low, 0);
    chk("mid_rst_busy", tx_busy, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    chk("mid_rst_no_done", n_done - d0, 0);
    chk("mid_rst_no_err", n_err - e0, 0);
    start_frame(8'hED); device(1, 0); wait_idle();
    chk("post_rst_done", n_done - d0, 1);
    chk("post_rst_err", n_err - e0, 0);

    // Second request during a frame must be ignored
    d0 = n_done; e0 = n_err;
    start_frame(8'hED);
    fork
      device(1, 0);
      begin
        repeat (60) @(negedge clk);
        tx_data = 8'h00; tx_start = 1'b1;
        chk("repulse_busy", tx_busy, 1);
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_idle();
    chk("repulse_done", n_done - d0, 1);
    chk("repulse_err", n_err - e0, 0);
    chk("repulse_sb_empty", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    chk("repulse_stays_idle", tx_busy, 0);

    chk("never_both_pulses", n_both, 0);
    chk("no_data_change_clk_high", hi_changes, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
